// File: rtl/somador_serial_ctrl.sv
// Bit-serial adder/subtractor: one time-shared full-adder cell walks N bits LSB first.
// Latency: N clock edges from the edge accepting inicio to the pronto pulse; N+2 cycles between requests.
// Backpressure: inicio is ignored while ocupado=1 (CALCULA/FIM); nothing is queued.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   inicio, sub     start request and op select (0 = a+b, 1 = a-b), sampled in OCIOSO
//   a, b            N-bit operands, sampled with inicio
//   s, cout         result and final carry (subtract: cout=1 means no borrow), updated entering FIM
//   ocupado         high in CALCULA and FIM
//   pronto          one-cycle done pulse in FIM
//   overflow        signed overflow, only when SOMADOR_SERIAL_OVERFLOW_EN is defined
module somador_serial_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inicio,
   input  logic         sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ocupado,
   output logic         pronto
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
   ,output logic        overflow
`endif
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   estado_t       estado;
   logic [N-1:0]  ra;
   logic [N-1:0]  rb;
   // Only N-1 bits are stored: the final sum bit is merged directly into s.
   logic [N-2:0]  acc;
   logic          carry;
   logic [CW-1:0] cnt;

   // Full-adder cell built from two half adders; their carries are ORed.
   logic          ha1_soma;
   logic          ha1_carry;
   logic          soma;
   logic          ha2_carry;
   logic          carry_nx;
   logic [N-1:0]  acc_nx;

   assign ha1_soma  = ra[0] ^ rb[0];
   assign ha1_carry = ra[0] & rb[0];
   assign soma      = ha1_soma ^ carry;
   assign ha2_carry = ha1_soma & carry;
   assign carry_nx  = ha1_carry | ha2_carry;
   assign acc_nx    = {soma, acc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado  <= OCIOSO;
         ra      <= '0;
         rb      <= '0;
         acc     <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         s       <= '0;
         cout    <= 1'b0;
         ocupado <= 1'b0;
         pronto  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
         overflow <= 1'b0;
`endif
      end else begin
         case (estado)
            OCIOSO: begin
               if (inicio) begin
                  ra      <= a;
                  // Subtraction as a + ~b + 1: the +1 enters through the carry.
                  rb      <= sub ? ~b : b;
                  carry   <= sub;
                  cnt     <= '0;
                  ocupado <= 1'b1;
                  estado  <= CALCULA;
               end
            end
            CALCULA: begin
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               acc   <= acc_nx[N-1:1];
               carry <= carry_nx;
               cnt   <= cnt + CW'(1);
               if (cnt == ULTIMO) begin
                  s      <= acc_nx;
                  cout   <= carry_nx;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
                  // Signed overflow: carry into the sign bit differs from carry out of it.
                  overflow <= carry ^ carry_nx;
`endif
                  pronto <= 1'b1;
                  estado <= FIM;
               end
            end
            FIM: begin
               pronto  <= 1'b0;
               ocupado <= 1'b0;
               estado  <= OCIOSO;
            end
            default: begin
               pronto  <= 1'b0;
               ocupado <= 1'b0;
               estado  <= OCIOSO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
module tb_somador_serial_ctrl;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         inicio;
   logic         sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] s;
   logic         cout;
   logic         ocupado;
   logic         pronto;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
   logic         overflow;
`endif

   int checks   = 0;
   int failures = 0;

   // Last result the DUT should be holding on s/cout.
   logic [N-1:0] hold_s;
   logic         hold_c;

   somador_serial_ctrl #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inicio  (inicio),
      .sub     (sub),
      .a       (a),
      .b       (b),
      .s       (s),
      .cout    (cout),
      .ocupado (ocupado),
      .pronto  (pronto)
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      ,.overflow (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic logic [N:0] modelo(input logic [N-1:0] x, input logic [N-1:0] y, input logic op);
      int r;
      logic [N-1:0] rs;
      logic rc;
      if (op) begin
         r  = int'(x) - int'(y);
         rc = (x >= y);
      end else begin
         r  = int'(x) + int'(y);
         rc = (r >= (1 << N));
      end
      rs = N'((r + (1 << N)) % (1 << N));
      return {rc, rs};
   endfunction

   function automatic logic modelo_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic op);
      int sx, sy, r;
      sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
      sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
      r  = op ? sx - sy : sx + sy;
      return (r > (1 << (N-1)) - 1) || (r < -(1 << (N-1)));
   endfunction

   // One complete operation with timing, hold and result checks.
   task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y, input logic op);
      logic [N:0] exp;
      int k;
      int busy;
      exp = modelo(x, y, op);
      @(negedge clk);
      a = x; b = y; sub = op; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      // Captured operands must be immune to later input changes.
      a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
      chk({tag, "_ocupado_e0"}, 32'(ocupado), 32'd1);
      chk({tag, "_pronto_e0"}, 32'(pronto), 32'd0);
      chk({tag, "_s_held"}, 32'(s), 32'(hold_s));
      busy = 1;
      k = 0;
      while (k < 40) begin
         @(posedge clk); #1;
         k++;
         if (ocupado) busy++;
         if (pronto) break;
      end
      chk({tag, "_latency"}, 32'(k), 32'(N));
      chk({tag, "_busy_cycles"}, 32'(busy), 32'(N + 1));
      chk({tag, "_s"}, 32'(s), 32'(exp[N-1:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(exp[N]));
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(overflow), 32'(modelo_ovf(x, y, op)));
`endif
      hold_s = exp[N-1:0];
      hold_c = exp[N];
      @(posedge clk); #1;
      chk({tag, "_pronto_fall"}, 32'(pronto), 32'd0);
      chk({tag, "_ocupado_fall"}, 32'(ocupado), 32'd0);
   endtask

   initial begin
      int pr_cnt;
      int pr_first;
      logic [N:0] e;

      rst_n = 1'b1; inicio = 1'b0; sub = 1'b0; a = '0; b = '0;
      hold_s = '0; hold_c = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_pronto", 32'(pronto), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      chk("rst_ovf", 32'(overflow), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      do_op("add_nc", 8'h35, 8'h4A, 1'b0);
      do_op("add_wrap", 8'hFF, 8'h01, 1'b0);
      do_op("sub_pos", 8'h10, 8'h01, 1'b1);
      do_op("sub_borrow", 8'h01, 8'h02, 1'b1);

      // Busy rejection: inicio held high with a=0 throughout.
      @(negedge clk);
      a = 8'h35; b = 8'h4A; sub = 1'b0; inicio = 1'b1;
      @(posedge clk); #1;
      a = 8'h00;
      pr_cnt = 0; pr_first = -1;
      for (int i = 1; i <= 2 * N + 2; i++) begin
         @(posedge clk); #1;
         if (pronto) begin
            pr_cnt++;
            if (pr_first < 0) begin
               pr_first = i;
               chk("busy_first_s", 32'(s), 32'h7F);
            end
         end
         if (i == N + 1) chk("busy_idle_en1", 32'(ocupado), 32'd0);
         if (i == N + 2) chk("busy_accept_en2", 32'(ocupado), 32'd1);
      end
      inicio = 1'b0;
      chk("busy_pronto_count", 32'(pr_cnt), 32'd2);
      chk("busy_pronto_first", 32'(pr_first), 32'(N));
      chk("busy_second_s", 32'(s), 32'h4A);
      hold_s = 8'h4A; hold_c = 1'b0;
      @(posedge clk); #1;
      chk("busy_done_idle", 32'(ocupado), 32'd0);

      // Reset in the middle of a computation.
      @(negedge clk);
      a = 8'h12; b = 8'h34; sub = 1'b0; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_s", 32'(s), 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
      chk("mid_rst_pronto", 32'(pronto), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hold_s = '0; hold_c = 1'b0;
      pr_cnt = 0;
      repeat (N + 3) begin
         @(posedge clk); #1;
         if (pronto) pr_cnt++;
      end
      chk("mid_rst_no_pronto", 32'(pr_cnt), 32'd0);
      do_op("after_rst", 8'hC3, 8'h5A, 1'b1);

`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      do_op("ovf_add", 8'h7F, 8'h01, 1'b0);
      chk("ovf_add_flag", 32'(overflow), 32'd1);
      do_op("ovf_sub", 8'h80, 8'h01, 1'b1);
      chk("ovf_sub_flag", 32'(overflow), 32'd1);
      do_op("ovf_none", 8'h35, 8'h4A, 1'b0);
      chk("ovf_none_flag", 32'(overflow), 32'd0);
`endif

      // Randomized operations against the model.
      for (int i = 0; i < 20; i++) begin
         logic [N-1:0] x, y;
         logic op;
         x  = N'($urandom);
         y  = N'($urandom);
         op = 1'($urandom);
         do_op("rand", x, y, op);
      end

      // s/cout held while idle.
      repeat (5) @(posedge clk);
      #1;
      e = {hold_c, hold_s};
      chk("idle_hold_s", 32'(s), 32'(e[N-1:0]));
      chk("idle_hold_cout", 32'(cout), 32'(e[N]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
